// File: rtl/wallace_mult_pkg.sv
// Shared helpers for the pipelined Wallace-tree multiplier: operand extension
// and reduction-tree sizing used to build the compression levels.
package wallace_mult_pkg;

    localparam int MAX_WIDTH = 32;
    localparam int MAX_PW    = 2 * MAX_WIDTH;

    // Extend the low 'width' bits of x to MAX_PW bits, by MSB when signed, else by zeros.
    function automatic logic [MAX_PW-1:0] sext_or_zext(input logic [MAX_WIDTH-1:0] x,
                                                       input logic                 is_signed,
                                                       input int                   width);
        logic [MAX_PW-1:0] r;
        logic [4:0]        msb;
        logic              fill;
        msb  = 5'(width - 1);
        fill = is_signed & x[msb];
        r    = '0;
        for (int i = 0; i < MAX_PW; i++) begin
            r[i] = (i < width) ? x[i[4:0]] : fill;
        end
        return r;
    endfunction

    // Each Wallace level turns every group of three rows into two.
    function automatic int rows_after_levels(input int height, input int levels);
        int h;
        h = height;
        for (int l = 0; l < levels; l++) begin
            h = h - h / 3;
        end
        return h;
    endfunction

    // Number of levels needed to bring 'height' rows down to two.
    function automatic int num_reduction_levels(input int height);
        int h;
        int n;
        h = height;
        n = 0;
        while (h > 2) begin
            h = h - h / 3;
            n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/wallace_mult_pipe_csa_row.sv
// Row of full adders compressing three W-bit rows into a sum row and a carry
// row; the carry row is already shifted up one column and its top carry dropped.
module csa_row #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] s,
    output logic [W-1:0] c
);

    // Per-column sum bit and majority carry into the next column.
    always_comb begin
        s = x ^ y ^ z;
        c = '0;
        for (int i = 1; i < W; i++) begin
            c[i] = (x[i-1] & y[i-1]) | (x[i-1] & z[i-1]) | (y[i-1] & z[i-1]);
        end
    end

endmodule

// File: rtl/wallace_mult_pipe.sv
// Three-stage pipelined Wallace-tree multiplier with per-operand signed/unsigned
// selection. S1: partial-product matrix, S2: tree reduction to sum/carry,
// S3: final carry-propagate add. One global enable stalls every stage.
module wallace_mult_pipe
    import wallace_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 a_signed,
    input  logic                 b_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p
);

    localparam int PW     = 2 * WIDTH;
    localparam int LEVELS = num_reduction_levels(PW);

    logic          en;
    logic          v1, v2, v3;
    logic [PW-1:0] ext_a, ext_b;
    logic [PW-1:0] pp_q [PW];
    logic [PW-1:0] lvl  [LEVELS+1][PW];
    logic [PW-1:0] sum_q, carry_q;

    assign en        = !v3 || out_ready;
    assign in_ready  = en;
    assign out_valid = v3;

    // Mode bits are consumed here, so each beat carries its own signedness forward.
    assign ext_a = PW'(sext_or_zext(MAX_WIDTH'(a), a_signed, WIDTH));
    assign ext_b = PW'(sext_or_zext(MAX_WIDTH'(b), b_signed, WIDTH));

    // S1: register the AND array; row j is ext_a shifted by j, gated by ext_b[j].
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            for (int j = 0; j < PW; j++) pp_q[j] <= '0;
        end else if (en) begin
            v1 <= in_valid;
            if (in_valid) begin
                for (int j = 0; j < PW; j++) pp_q[j] <= ext_b[j] ? (ext_a << j) : '0;
            end
        end
    end

    for (genvar j = 0; j < PW; j++) begin : g_lvl0
        assign lvl[0][j] = pp_q[j];
    end

    // Leftover rows that do not fill a group of three pass straight through.
    for (genvar l = 0; l < LEVELS; l++) begin : g_level
        localparam int HIN  = rows_after_levels(PW, l);
        localparam int NG   = HIN / 3;
        localparam int HOUT = HIN - NG;

        for (genvar g = 0; g < NG; g++) begin : g_csa
            csa_row #(.W(PW)) u_csa (
                .x (lvl[l][3*g]),
                .y (lvl[l][3*g+1]),
                .z (lvl[l][3*g+2]),
                .s (lvl[l+1][2*g]),
                .c (lvl[l+1][2*g+1])
            );
        end
        for (genvar r = 3*NG; r < HIN; r++) begin : g_pass
            assign lvl[l+1][2*NG + r - 3*NG] = lvl[l][r];
        end
        for (genvar r = HOUT; r < PW; r++) begin : g_zero
            assign lvl[l+1][r] = '0;
        end
    end

    // S2: capture the two surviving rows of the tree.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2      <= 1'b0;
            sum_q   <= '0;
            carry_q <= '0;
        end else if (en) begin
            v2 <= v1;
            if (v1) begin
                sum_q   <= lvl[LEVELS][0];
                carry_q <= lvl[LEVELS][1];
            end
        end
    end

    // S3: final carry-propagate add; carry out of the top column is discarded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v3 <= 1'b0;
            p  <= '0;
        end else if (en) begin
            v3 <= v2;
            if (v2) p <= sum_q + carry_q;
        end
    end

endmodule

// File: doc/wallace_mult_pipe.md
Name: wallace_mult_pipe

Overview:
- Parametrised, pipelined Wallace-tree multiplier. Next generation of the team's fixed 4-bit combinational Wallace multiplier.
- Supports per-transaction signed or unsigned selection on each operand independently.
- Has a 3-stage pipeline with valid/ready handshake on both sides.
- Sits in the datapath between operand-issue logic and the accumulate/writeback stage.

Parameters:
- WIDTH, 8, operand width in bits (legal range 4..32). Product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- a_signed  input  1  1 = a is two's complement, 0 = unsigned
- b_signed  input  1  1 = b is two's complement, 0 = unsigned
- out_valid  output  1  product valid
- out_ready  input  1  downstream accepts product
- p  output  2*WIDTH  product

Behaviour:
- Interface: single clock, synchronous active-low reset (rst_n sampled on rising clk).
- Reset values:
  - out_valid=0, p=0.
  - All internal stage valids = 0.
  - in_ready=1 in the first cycle after reset deassertion.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Pipeline:
  - S1 registers the sign-extended (2*WIDTH) operands and the partial-product matrix (AND array).
  - S2 reduces the matrix by Wallace 3:2/2:2 compression to two rows (sum, carry) and registers them.
  - S3 registers the final carry-propagate sum into p.
- Latency: 3 cycles from accepted input to out_valid when unstalled. Throughput is 1 beat/cycle.
- Arithmetic:
  - Operand x is extended to 2*WIDTH bits with its MSB when x_signed=1, otherwise with zeros.
  - p = ext(a)*ext(b) mod 2^(2*WIDTH). This is exact for all four sign combinations.
  - Partial products only need columns 0..2*WIDTH-1. Carries out of bit 2*WIDTH-1 are discarded.
- Stall: global enable en = !out_valid || out_ready, and in_ready = en.
  - When en=0, every stage register (data and valid) holds.
  - Bubbles are not compressed.
- Stability rule: while out_valid=1 and out_ready=0, p stays stable until the beat is accepted.
- Simultaneous accept in/out on a full pipe: both transfers occur in the same cycle and the pipe shifts.
- Mode bits travel with the data. A sign change between consecutive beats never affects in-flight beats.
- Reset mid-operation: all in-flight beats are dropped, and outputs return to reset values on the next edge.
- No X propagation: stage data registers load only when the upstream valid is set. When invalid, the contents are don't-care but must be reset to 0.

Decomposition:
- Package wallace_mult_pkg holds:
  - function sext_or_zext(x, is_signed, width)
  - localparam PW = 2*WIDTH
  - function num_reduction_levels(height), giving Wallace level count for a given matrix height, used to size generate loops.
- One natural sub-module: csa_row, a vector of full adders acting as a 3:2 compressor of width PW. S2 instantiates it per level inside a generate loop. Half-adder cells are inline.
- The pipeline control (en, valids) stays in the top module. No FSM beyond the per-stage valid bits.

Test Plan:
- WIDTH=8, a=0x80, b=0x80, a_signed=b_signed=1, out_ready=1 -> out_valid exactly 3 cycles after accept, p=0x4000.
- WIDTH=8, a=0xFF, b=0xFF: unsigned/unsigned -> p=0xFE01; signed/signed -> p=0x0001; a_signed=1, b_signed=0 -> p=0xFF01.
- WIDTH=4, a=0x8, b=0xF, a_signed=1, b_signed=0 -> p=0x88 (-120). Then sweep all 256 operand pairs × 4 modes against the reference model (integer multiply of extended operands).
- Back-to-back: 20 random beats, in_valid=1 continuously, out_ready=1 -> 20 consecutive out_valid cycles, order preserved, in_ready never low.
- Backpressure: fill pipe, then out_ready=0 for 5 cycles -> in_ready=0 after 3 beats are queued, p/out_valid held stable. out_ready=1 -> beats drain in order with no loss or duplicate.
- Reset mid-stream: rst_n=0 for one cycle with 3 beats in flight -> next cycle out_valid=0, p=0, in_ready=1. No stale beat ever emerges.
